// File: rtl/multi_cycle_control_unit_if.sv
// Control/datapath bundle for the multi-cycle CPU sequencer.
// Master is the control unit, slave is the datapath side.
interface multi_cycle_control_unit_if;
  logic [5:0] opcode;
  logic       zero;
  logic       sign;
  logic       PCWre;
  logic       IRWre;
  logic       InsMemRW;
  logic       mRD;
  logic       mWR;
  logic       RegWre;
  logic       ALUSrcA;
  logic       ALUSrcB;
  logic       DBDataSrc;
  logic       WrRegDSrc;
  logic [1:0] RegDst;
  logic       ExtSel;
  logic [1:0] PCSrc;
  logic [2:0] ALUOp;
  logic [2:0] state;

  modport master (
    input  opcode, zero, sign,
    output PCWre, IRWre, InsMemRW,
    output mRD, mWR, RegWre,
    output ALUSrcA, ALUSrcB,
    output DBDataSrc, WrRegDSrc,
    output RegDst, ExtSel, PCSrc,
    output ALUOp, state
  );

  modport slave (
    output opcode, zero, sign,
    input  PCWre, IRWre, InsMemRW,
    input  mRD, mWR, RegWre,
    input  ALUSrcA, ALUSrcB,
    input  DBDataSrc, WrRegDSrc,
    input  RegDst, ExtSel, PCSrc,
    input  ALUOp, state
  );
endinterface

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle CPU sequencer: IF/ID/EXE/MEM/WB stepping and
// combinational datapath controls decoded from state + opcode.
module multi_cycle_control_unit #(
  parameter logic [5:0] OP_HALT = 6'b111111
) (
  input logic                         CLK,
  input logic                         Reset,
  multi_cycle_control_unit_if.master  bus
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_L   = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_halt;
  logic       w_halt_nxt;

  logic       w_alu;
  logic       w_rtype;
  logic       w_imm;
  logic       w_sll;
  logic       w_zext;
  logic       w_ls;
  logic       w_br;
  logic       w_jmp;
  logic       w_jr;
  logic       w_jal;
  logic       w_sw;
  logic       w_hlt;
  logic       w_taken;
  logic [2:0] w_aluop;

  always_comb begin
    w_alu   = 1'b0;
    w_rtype = 1'b0;
    w_imm   = 1'b0;
    w_sll   = 1'b0;
    w_zext  = 1'b0;
    w_ls    = 1'b0;
    w_br    = 1'b0;
    w_jmp   = 1'b0;
    w_aluop = 3'b000;
    case (bus.opcode)
      6'b000000: begin
        w_alu   = 1'b1;
        w_rtype = 1'b1;
      end
      6'b000001: begin
        w_alu   = 1'b1;
        w_rtype = 1'b1;
        w_aluop = 3'b001;
      end
      6'b000010: begin
        w_alu   = 1'b1;
        w_imm   = 1'b1;
      end
      6'b010000: begin
        w_alu   = 1'b1;
        w_rtype = 1'b1;
        w_aluop = 3'b110;
      end
      6'b010001: begin
        w_alu   = 1'b1;
        w_imm   = 1'b1;
        w_zext  = 1'b1;
        w_aluop = 3'b110;
      end
      6'b010010: begin
        w_alu   = 1'b1;
        w_imm   = 1'b1;
        w_zext  = 1'b1;
        w_aluop = 3'b101;
      end
      6'b010011: begin
        w_alu   = 1'b1;
        w_imm   = 1'b1;
        w_zext  = 1'b1;
        w_aluop = 3'b111;
      end
      6'b011000: begin
        w_alu   = 1'b1;
        w_rtype = 1'b1;
        w_sll   = 1'b1;
        w_aluop = 3'b100;
      end
      6'b100110: begin
        w_alu   = 1'b1;
        w_imm   = 1'b1;
        w_aluop = 3'b011;
      end
      6'b100111: begin
        w_alu   = 1'b1;
        w_rtype = 1'b1;
        w_aluop = 3'b011;
      end
      6'b110000, 6'b110001: begin
        w_ls    = 1'b1;
        w_imm   = 1'b1;
      end
      6'b110100, 6'b110101, 6'b110110: begin
        w_br    = 1'b1;
        w_aluop = 3'b001;
      end
      6'b111000, 6'b111001, 6'b111010: begin
        w_jmp   = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_jr  = (bus.opcode == 6'b111001);
  assign w_jal = (bus.opcode == 6'b111010);
  assign w_sw  = (bus.opcode == 6'b110000);
  assign w_hlt = (bus.opcode == OP_HALT);

  always_comb begin
    w_taken = 1'b0;
    case (bus.opcode)
      6'b110100: w_taken = bus.zero;
      6'b110101: w_taken = ~bus.zero;
      6'b110110: w_taken = bus.sign;
      default:   w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IF;
      r_halt  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_halt  <= w_halt_nxt;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_halt_nxt    = r_halt;
    bus.state     = r_state;
    bus.PCWre     = 1'b0;
    bus.IRWre     = 1'b0;
    bus.InsMemRW  = 1'b0;
    bus.mRD       = 1'b0;
    bus.mWR       = 1'b0;
    bus.RegWre    = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = 1'b0;
    bus.DBDataSrc = 1'b0;
    bus.WrRegDSrc = 1'b0;
    bus.RegDst    = 2'b00;
    bus.ExtSel    = ~w_zext;
    bus.PCSrc     = 2'b00;
    bus.ALUOp     = 3'b000;
    // Halted: parked in ID with every enable low until reset.
    if (r_halt) begin
      bus.state = S_ID;
    end else begin
      unique case (r_state)
        S_IF: begin
          bus.IRWre    = 1'b1;
          bus.InsMemRW = 1'b1;
          w_next       = S_ID;
        end
        S_ID: begin
          unique case (1'b1)
            w_alu: w_next = S_EXE_AL;
            w_ls:  w_next = S_EXE_LS;
            w_br:  w_next = S_EXE_BR;
            w_jmp: begin
              bus.PCWre = 1'b1;
              bus.PCSrc = w_jr ? 2'b10 : 2'b11;
              bus.RegWre = w_jal;
              w_next    = S_IF;
            end
            w_hlt: w_halt_nxt = 1'b1;
            default: begin
              bus.PCWre = 1'b1;
              w_next    = S_IF;
            end
          endcase
        end
        S_EXE_AL: begin
          bus.ALUOp   = w_aluop;
          bus.ALUSrcA = w_sll;
          bus.ALUSrcB = w_imm;
          w_next      = S_WB_AL;
        end
        S_WB_AL: begin
          bus.ALUOp     = w_aluop;
          bus.ALUSrcA   = w_sll;
          bus.ALUSrcB   = w_imm;
          bus.RegWre    = 1'b1;
          bus.PCWre     = 1'b1;
          bus.WrRegDSrc = 1'b1;
          bus.RegDst    = w_rtype ? 2'b10 : 2'b01;
          w_next        = S_IF;
        end
        S_EXE_LS: begin
          bus.ALUOp   = w_aluop;
          bus.ALUSrcB = w_imm;
          w_next      = S_MEM;
        end
        S_MEM: begin
          bus.ALUOp   = w_aluop;
          bus.ALUSrcB = w_imm;
          if (w_sw) begin
            bus.mWR   = 1'b1;
            bus.PCWre = 1'b1;
            w_next    = S_IF;
          end else begin
            bus.mRD   = 1'b1;
            w_next    = S_WB_L;
          end
        end
        S_WB_L: begin
          bus.RegWre    = 1'b1;
          bus.DBDataSrc = 1'b1;
          bus.WrRegDSrc = 1'b1;
          bus.RegDst    = 2'b01;
          bus.PCWre     = 1'b1;
          w_next        = S_IF;
        end
        S_EXE_BR: begin
          bus.ALUOp = w_aluop;
          bus.PCWre = 1'b1;
          bus.PCSrc = w_taken ? 2'b01 : 2'b00;
          w_next    = S_IF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Randomized instruction stream against a phase-based reference model,
// plus directed literal checks for reset, each class, and halt.
module tb_multi_cycle_control_unit;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  multi_cycle_control_unit_if bus ();

  multi_cycle_control_unit #(
    .OP_HALT(6'b111111)
  ) dut (
    .CLK(CLK),
    .Reset(Reset),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [5:0] cur_op;
  int k;
  bit halted;
  bit force_zs;
  logic fz, fs;

  logic [2:0] e_state, e_aluop;
  logic [1:0] e_regdst, e_pcsrc;
  logic e_pcwre, e_ir, e_imr, e_mrd, e_mwr, e_regwre;
  logic e_srca, e_srcb, e_dbsrc, e_wrsrc, e_ext;

  logic [2:0] o_state [8];
  logic [2:0] o_aluop [8];
  logic [1:0] o_regdst [8];
  logic [1:0] o_pcsrc [8];
  logic o_pcwre [8];
  logic o_regwre [8];
  logic o_mrd [8];
  logic o_mwr [8];
  logic o_srcb [8];
  logic o_dbsrc [8];
  logic o_wrsrc [8];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit f_alu(input logic [5:0] op);
    return op inside {6'd0, 6'd1, 6'd2, 6'd16, 6'd17,
                      6'd18, 6'd19, 6'd24, 6'd38, 6'd39};
  endfunction

  function automatic bit f_rt(input logic [5:0] op);
    return op inside {6'd0, 6'd1, 6'd16, 6'd24, 6'd39};
  endfunction

  function automatic bit f_zx(input logic [5:0] op);
    return op inside {6'd17, 6'd18, 6'd19};
  endfunction

  function automatic bit f_imm(input logic [5:0] op);
    return op inside {6'd2, 6'd17, 6'd18, 6'd19,
                      6'd38, 6'd48, 6'd49};
  endfunction

  function automatic bit f_br(input logic [5:0] op);
    return op inside {6'd52, 6'd53, 6'd54};
  endfunction

  function automatic bit f_known(input logic [5:0] op);
    return f_alu(op) || f_br(op) ||
           op inside {6'd48, 6'd49, 6'd56, 6'd57, 6'd58, 6'd63};
  endfunction

  function automatic logic [2:0] f_aop(input logic [5:0] op);
    case (op)
      6'd1, 6'd52, 6'd53, 6'd54: return 3'd1;
      6'd16, 6'd17:              return 3'd6;
      6'd18:                     return 3'd5;
      6'd19:                     return 3'd7;
      6'd24:                     return 3'd4;
      6'd38, 6'd39:              return 3'd3;
      default:                   return 3'd0;
    endcase
  endfunction

  function automatic int ilen(input logic [5:0] op);
    if (f_alu(op)) return 4;
    if (op == 6'd49) return 5;
    if (op == 6'd48) return 4;
    if (f_br(op)) return 3;
    return 2;
  endfunction

  // state code visited at phase kk of an instruction
  function automatic logic [2:0] f_seq(input logic [5:0] op, input int kk);
    if (kk < 2) return 3'(kk);
    if (f_alu(op)) return 3'(kk + 4);
    if (f_br(op)) return 3'd5;
    return 3'(kk);
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] tbl [19];
    logic [5:0] op;
    tbl = '{6'd0, 6'd1, 6'd2, 6'd16, 6'd17, 6'd18, 6'd19,
            6'd24, 6'd38, 6'd39, 6'd48, 6'd49, 6'd52, 6'd53,
            6'd54, 6'd56, 6'd57, 6'd58, 6'd49};
    if ($urandom_range(0, 9) != 0)
      return tbl[$urandom_range(0, 18)];
    do op = 6'($urandom_range(0, 63));
    while (f_known(op));
    return op;
  endfunction

  task automatic begin_cycle();
    int L;
    bit fin, win, tk, res;
    if (force_zs) begin
      bus.zero = fz;
      bus.sign = fs;
    end else begin
      bus.zero = 1'($urandom_range(0, 1));
      bus.sign = 1'($urandom_range(0, 1));
    end
    L   = ilen(cur_op);
    fin = (k == L - 1);
    win = (f_alu(cur_op) && k >= 2) ||
          (cur_op inside {6'd48, 6'd49} && k inside {2, 3}) ||
          (f_br(cur_op) && k == 2);
    tk  = (cur_op == 6'd52) ? bus.zero :
          (cur_op == 6'd53) ? !bus.zero : bus.sign;
    res = f_alu(cur_op) || cur_op == 6'd49;
    e_ext = !f_zx(cur_op);
    if (halted) begin
      e_state = 3'd1;
      {e_pcwre, e_ir, e_imr, e_mrd, e_mwr, e_regwre} = '0;
      {e_srca, e_srcb, e_dbsrc, e_wrsrc} = '0;
      e_regdst = 2'd0;
      e_pcsrc = 2'd0;
      e_aluop = 3'd0;
    end else begin
      e_state  = f_seq(cur_op, k);
      e_ir     = (k == 0);
      e_imr    = (k == 0);
      e_pcwre  = fin && cur_op != 6'd63;
      e_mrd    = cur_op == 6'd49 && k == 3;
      e_mwr    = cur_op == 6'd48 && k == 3;
      e_regwre = (res && fin) || (cur_op == 6'd58 && k == 1);
      e_dbsrc  = cur_op == 6'd49 && k == 4;
      e_wrsrc  = res && fin;
      e_regdst = (f_alu(cur_op) && fin) ? (f_rt(cur_op) ? 2'd2 : 2'd1) :
                 (cur_op == 6'd49 && fin) ? 2'd1 : 2'd0;
      e_pcsrc  = (k == 1 && cur_op == 6'd57) ? 2'd2 :
                 (k == 1 && cur_op inside {6'd56, 6'd58}) ? 2'd3 :
                 (f_br(cur_op) && k == 2 && tk) ? 2'd1 : 2'd0;
      e_aluop  = win ? f_aop(cur_op) : 3'd0;
      e_srca   = win && cur_op == 6'd24;
      e_srcb   = win && f_imm(cur_op);
    end
    chk_en = 1'b1;
    #2;
    if (!halted && k < 8) begin
      o_state[k]  = bus.state;
      o_aluop[k]  = bus.ALUOp;
      o_regdst[k] = bus.RegDst;
      o_pcsrc[k]  = bus.PCSrc;
      o_pcwre[k]  = bus.PCWre;
      o_regwre[k] = bus.RegWre;
      o_mrd[k]    = bus.mRD;
      o_mwr[k]    = bus.mWR;
      o_srcb[k]   = bus.ALUSrcB;
      o_dbsrc[k]  = bus.DBDataSrc;
      o_wrsrc[k]  = bus.WrRegDSrc;
    end
  endtask

  task automatic end_cycle();
    @(posedge CLK);
    #1;
    if (!halted) begin
      if (k == ilen(cur_op) - 1) begin
        if (cur_op == 6'd63) halted = 1'b1;
        else k = 0;
      end else begin
        k++;
      end
    end
  endtask

  task automatic run_op(input logic [5:0] op, input bit frc,
                        input logic z, input logic s);
    cur_op = op;
    bus.opcode = op;
    force_zs = frc;
    fz = z;
    fs = s;
    repeat (ilen(op)) begin
      begin_cycle();
      end_cycle();
    end
    force_zs = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("state", bus.state, e_state);
      check("PCWre", bus.PCWre, e_pcwre);
      check("IRWre", bus.IRWre, e_ir);
      check("InsMemRW", bus.InsMemRW, e_imr);
      check("mRD", bus.mRD, e_mrd);
      check("mWR", bus.mWR, e_mwr);
      check("RegWre", bus.RegWre, e_regwre);
      check("ALUSrcA", bus.ALUSrcA, e_srca);
      check("ALUSrcB", bus.ALUSrcB, e_srcb);
      check("DBDataSrc", bus.DBDataSrc, e_dbsrc);
      check("WrRegDSrc", bus.WrRegDSrc, e_wrsrc);
      check("RegDst", bus.RegDst, e_regdst);
      check("ExtSel", bus.ExtSel, e_ext);
      check("PCSrc", bus.PCSrc, e_pcsrc);
      check("ALUOp", bus.ALUOp, e_aluop);
    end
  end

  initial begin
    logic pc_seen, rw_seen;
    Reset = 1'b0;
    bus.opcode = 6'd0;
    bus.zero = 1'b0;
    bus.sign = 1'b0;
    force_zs = 1'b0;
    fz = 1'b0;
    fs = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_state", bus.state, 3'd0);
    check("rst_IRWre", bus.IRWre, 1'b1);
    check("rst_PCWre", bus.PCWre, 1'b0);
    Reset = 1'b1;
    k = 0;
    halted = 1'b0;

    run_op(6'd0, 1'b0, 1'b0, 1'b0);
    check("add_seq", {o_state[0], o_state[1], o_state[2], o_state[3]},
          12'o0167);
    check("add_wb_regwre", o_regwre[3], 1'b1);
    check("add_wb_regdst", o_regdst[3], 2'b10);
    check("add_wb_aluop", o_aluop[3], 3'b000);
    check("add_wb_srcb", o_srcb[3], 1'b0);
    check("add_wb_pcwre", o_pcwre[3], 1'b1);

    run_op(6'd49, 1'b0, 1'b0, 1'b0);
    check("lw_seq", {o_state[2], o_state[3], o_state[4]}, 9'o234);
    check("lw_mem_mrd", o_mrd[3], 1'b1);
    check("lw_mem_mwr", o_mwr[3], 1'b0);
    check("lw_wb_dbsrc", o_dbsrc[4], 1'b1);
    check("lw_wb_regdst", o_regdst[4], 2'b01);

    run_op(6'd48, 1'b0, 1'b0, 1'b0);
    rw_seen = o_regwre[0] | o_regwre[1] | o_regwre[2] | o_regwre[3];
    check("sw_mem_mwr", o_mwr[3], 1'b1);
    check("sw_regwre_never", rw_seen, 1'b0);
    check("sw_back_if", bus.state, 3'd0);

    run_op(6'd52, 1'b1, 1'b1, 1'b0);
    check("beq_z1_pcsrc", o_pcsrc[2], 2'b01);
    check("beq_aluop", o_aluop[2], 3'b001);
    run_op(6'd52, 1'b1, 1'b0, 1'b0);
    check("beq_z0_pcsrc", o_pcsrc[2], 2'b00);
    run_op(6'd53, 1'b1, 1'b0, 1'b0);
    check("bne_z0_pcsrc", o_pcsrc[2], 2'b01);
    run_op(6'd54, 1'b1, 1'b0, 1'b1);
    check("bltz_s1_pcsrc", o_pcsrc[2], 2'b01);
    check("bltz_aluop", o_aluop[2], 3'b001);

    run_op(6'd58, 1'b0, 1'b0, 1'b0);
    check("jal_pcsrc", o_pcsrc[1], 2'b11);
    check("jal_regwre", o_regwre[1], 1'b1);
    check("jal_regdst", o_regdst[1], 2'b00);
    check("jal_wrsrc", o_wrsrc[1], 1'b0);
    check("jal_back_if", bus.state, 3'd0);
    run_op(6'd57, 1'b0, 1'b0, 1'b0);
    check("jr_pcsrc", o_pcsrc[1], 2'b10);

    repeat (300) run_op(pick_op(), 1'b0, 1'b0, 1'b0);

    run_op(6'd63, 1'b0, 1'b0, 1'b0);
    pc_seen = 1'b0;
    repeat (20) begin
      begin_cycle();
      pc_seen |= bus.PCWre;
      end_cycle();
    end
    check("halt_pcwre_20", pc_seen, 1'b0);
    check("halt_state", bus.state, 3'd1);
    begin_cycle();
    Reset = 1'b0;
    chk_en = 1'b0;
    #1;
    check("halt_areset_state", bus.state, 3'd0);
    check("halt_areset_irwre", bus.IRWre, 1'b1);
    @(posedge CLK);
    #1;
    Reset = 1'b1;
    k = 0;
    halted = 1'b0;

    cur_op = 6'd48;
    bus.opcode = 6'd48;
    repeat (3) begin
      begin_cycle();
      end_cycle();
    end
    begin_cycle();
    check("sw_pre_rst_mwr", bus.mWR, 1'b1);
    Reset = 1'b0;
    chk_en = 1'b0;
    #1;
    check("sw_rst_mwr", bus.mWR, 1'b0);
    check("sw_rst_state", bus.state, 3'd0);
    @(posedge CLK);
    #1;
    Reset = 1'b1;
    k = 0;

    repeat (10) run_op(pick_op(), 1'b0, 1'b0, 1'b0);
    chk_en = 1'b0;
    @(posedge CLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
